uart_dma: RTL

//  DMA responder for the uart block's FIFO request lines. Drains the RX FIFO into memory and fills the TX FIFO from memory.
//  It drives the uart pop/push level strobes with the HI/LO pacing the uart's 2-flop edge detectors require.

---
 rtl/uart_dma_pkg.sv | 19 +
 rtl/uart_dma_strobe.sv | 53 +++++
 rtl/uart_dma.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_dma_pkg.sv
// Shared types and constants for the uart DMA responder.
// Holds the beat FSM encoding and the sizing of the strobe pacing counter.
package uart_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_MEM,
        RX_HI,
        RX_LO,
        TX_MEM,
        TX_HI,
        TX_LO
    } uart_dma_state_t;

    localparam int STB_CW     = 4;
    localparam int STB_HI_DEF = 2;
    localparam int STB_LO_DEF = 2;

endpackage

// File: rtl/uart_dma_strobe.sv
// HI/LO pacing for the uart pop/push level strobes.
// A go pulse gives hi_cyc cycles of stb=1, then lo_cyc cycles of stb=0; fin marks the last LO cycle.
module uart_dma_strobe
    import uart_dma_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              go,
    input  logic [STB_CW-1:0] hi_cyc,
    input  logic [STB_CW-1:0] lo_cyc,
    output logic              stb,
    output logic              fin
);

    typedef enum logic [1:0] {PH_OFF, PH_HI, PH_LO} phase_t;

    phase_t            phase;
    logic [STB_CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            phase <= PH_OFF;
            cnt   <= '0;
        end else if (go) begin
            phase <= PH_HI;
            cnt   <= '0;
        end else begin
            case (phase)
                PH_HI: begin
                    if (cnt == hi_cyc - STB_CW'(1)) begin
                        phase <= PH_LO;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + STB_CW'(1);
                    end
                end
                PH_LO: begin
                    if (fin) begin
                        phase <= PH_OFF;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + STB_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign stb = (phase == PH_HI);
    assign fin = (phase == PH_LO) && (cnt == lo_cyc - STB_CW'(1));

endmodule

// File: rtl/uart_dma.sv
// DMA responder moving bytes between the uart FIFOs and a byte-wide memory port.
// Define UART_DMA_CIRC_EN for circular mode (channels reload base/len and stay armed).
module uart_dma
    import uart_dma_pkg::*;
#(
    parameter int AW     = 16,
    parameter int LW     = 16,
    parameter int STB_HI = STB_HI_DEF,
    parameter int STB_LO = STB_LO_DEF
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          rx_start,
    input  logic          tx_start,
    input  logic          abort,
    input  logic [AW-1:0] rx_base,
    input  logic [LW-1:0] rx_len,
    input  logic [AW-1:0] tx_base,
    input  logic [LW-1:0] tx_len,
    output logic          rx_busy,
    output logic          tx_busy,
    output logic          rx_done,
    output logic          tx_done,
    output logic [LW-1:0] rx_remain,
    output logic [LW-1:0] tx_remain,
    input  logic          rempty,
    input  logic          wfull,
    input  logic [7:0]    rchar,
    output logic [7:0]    wchar,
    output logic          pop,
    output logic          push,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack
);

    uart_dma_state_t state, state_nx;
    logic [AW-1:0]   rx_ptr, tx_ptr;
    logic            last_rx, abort_pend;
    logic            go, stb, fin;
    logic            rx_ok, tx_ok, serve_rx, kill;
`ifdef UART_DMA_CIRC_EN
    logic [AW-1:0]   rx_base_q, tx_base_q;
    logic [LW-1:0]   rx_len_q, tx_len_q;
`endif

    uart_dma_strobe u_strobe (
        .clk    (clk),
        .rstb   (rstb),
        .go     (go),
        .hi_cyc (STB_CW'(STB_HI)),
        .lo_cyc (STB_CW'(STB_LO)),
        .stb    (stb),
        .fin    (fin)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        go       = 1'b0;
        rx_ok    = rx_busy & ~rempty;
        tx_ok    = tx_busy & ~wfull;
        serve_rx = (rx_ok && tx_ok) ? ~last_rx : rx_ok;
        case (state)
            IDLE:   if (!abort && (rx_ok || tx_ok)) state_nx = serve_rx ? RX_MEM : TX_MEM;
            RX_MEM: if (mem_ack) begin state_nx = RX_HI; go = 1'b1; end
            RX_HI:  if (!stb) state_nx = RX_LO;
            RX_LO:  if (fin) state_nx = IDLE;
            TX_MEM: if (mem_ack) begin state_nx = TX_HI; go = 1'b1; end
            TX_HI:  if (!stb) state_nx = TX_LO;
            TX_LO:  if (fin) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // HI state covers the strobe-high cycles; the first LO cycle is spent leaving HI.
    assign pop  = stb && (state == RX_HI);
    assign push = stb && (state == TX_HI);
    assign kill = abort | abort_pend;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_busy <= 1'b0; tx_busy <= 1'b0; rx_done <= 1'b0; tx_done <= 1'b0;
            rx_remain <= '0; tx_remain <= '0; rx_ptr <= '0; tx_ptr <= '0;
            wchar <= '0; mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
            last_rx <= 1'b0; abort_pend <= 1'b0;
`ifdef UART_DMA_CIRC_EN
            rx_base_q <= '0; tx_base_q <= '0; rx_len_q <= '0; tx_len_q <= '0;
`endif
        end else begin
            rx_done <= 1'b0;
            tx_done <= 1'b0;
            if (state == IDLE && state_nx == RX_MEM) begin
                mem_req <= 1'b1; mem_we <= 1'b1; mem_addr <= rx_ptr; mem_wdata <= rchar;
                last_rx <= 1'b1;
            end
            if (state == IDLE && state_nx == TX_MEM) begin
                mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= tx_ptr;
                last_rx <= 1'b0;
            end
            if ((state == RX_MEM || state == TX_MEM) && mem_ack) mem_req <= 1'b0;
            if (state == TX_MEM && mem_ack) wchar <= mem_rdata;
            if (abort && state != IDLE) abort_pend <= 1'b1;

            if (state == RX_LO && fin) begin
                rx_ptr    <= rx_ptr + AW'(1);
                rx_remain <= rx_remain - LW'(1);
                if (rx_remain == LW'(1)) begin
                    rx_done <= ~kill;
`ifdef UART_DMA_CIRC_EN
                    if (!kill) begin rx_ptr <= rx_base_q; rx_remain <= rx_len_q; end
`else
                    rx_busy <= 1'b0;
`endif
                end
            end
            if (state == TX_LO && fin) begin
                tx_ptr    <= tx_ptr + AW'(1);
                tx_remain <= tx_remain - LW'(1);
                if (tx_remain == LW'(1)) begin
                    tx_done <= ~kill;
`ifdef UART_DMA_CIRC_EN
                    if (!kill) begin tx_ptr <= tx_base_q; tx_remain <= tx_len_q; end
`else
                    tx_busy <= 1'b0;
`endif
                end
            end

            // An abort lets the current beat finish its LO phase before disarming.
            if ((state == RX_LO || state == TX_LO) && fin && kill) begin
                rx_busy <= 1'b0; tx_busy <= 1'b0; abort_pend <= 1'b0;
            end
            if (abort && state == IDLE) begin
                rx_busy <= 1'b0; tx_busy <= 1'b0;
            end

            if (rx_start && !rx_busy) begin
                rx_ptr <= rx_base; rx_remain <= rx_len;
                rx_busy <= (rx_len != '0); rx_done <= (rx_len == '0);
`ifdef UART_DMA_CIRC_EN
                rx_base_q <= rx_base; rx_len_q <= rx_len;
`endif
            end
            if (tx_start && !tx_busy) begin
                tx_ptr <= tx_base; tx_remain <= tx_len;
                tx_busy <= (tx_len != '0); tx_done <= (tx_len == '0);
`ifdef UART_DMA_CIRC_EN
                tx_base_q <= tx_base; tx_len_q <= tx_len;
`endif
            end
        end
    end

endmodule
